// File: rtl/nco_cfg_ctrl_pkg.sv
// Shared definitions for DDS/NCO config-channel controllers: FSM states,
// sign-extension and {POFF,PINC} packing helpers sized for up to 64-bit words.
package nco_cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } nco_state_t;

  localparam int unsigned MAX_W  = 64;
  localparam int unsigned IDX_W  = $clog2(MAX_W);

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] hi;
    hi = {MAX_W{1'b1}} << w;
    return v[IDX_W'(w - 1)] ? (v | hi) : (v & ~hi);
  endfunction

  // Pack {poff, pinc} with each field pw bits wide (result right-aligned).
  function automatic logic [2*MAX_W-1:0] pack_cfg(input logic [MAX_W-1:0] poff,
                                                  input logic [MAX_W-1:0] pinc,
                                                  input int unsigned      pw);
    logic [2*MAX_W-1:0] lo_mask;
    lo_mask = ~({2*MAX_W{1'b1}} << pw);
    return ({{MAX_W{1'b0}}, poff} << pw) | ({{MAX_W{1'b0}}, pinc} & lo_mask);
  endfunction

endpackage

// File: rtl/nco_cfg_ctrl.sv
// Carrier NCO config sequencer: merges base_pinc with the latest loop correction
// and issues rate-limited AXI-Stream {POFF,PINC} config transfers.
module nco_cfg_ctrl
  import nco_cfg_ctrl_pkg::*;
#(
  parameter int PINC_WIDTH  = 32,
  parameter int CORR_WIDTH  = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_WIDTH   = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PINC_WIDTH-1:0]   base_pinc,
  input  logic [PINC_WIDTH-1:0]   phase_off,
  input  logic [CORR_WIDTH-1:0]   corr_tdata,
  input  logic                    corr_tvalid,
  output logic                    corr_tready,
  output logic [2*PINC_WIDTH-1:0] cfg_tdata,
  output logic                    cfg_tvalid,
  input  logic                    cfg_tready,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    update_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  localparam int HW    = $clog2(HOLD_CYCLES + 1);
  localparam int CFG_W = 2 * PINC_WIDTH;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  nco_state_t state, state_nxt;
  logic [HW-1:0]         hold_cnt;
  logic                  pending;
  logic [CORR_WIDTH-1:0] corr_reg;
  logic [PINC_WIDTH-1:0] base_q;
  logic                  build, use_corr, consume, hs, capture;
  logic [PINC_WIDTH-1:0] corr_ext, pinc_new;
  logic [CFG_W-1:0]      cfg_word;

  assign cfg_tvalid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign hs         = cfg_tvalid & cfg_tready;
  assign capture    = corr_tvalid & corr_tready;

  assign corr_ext = PINC_WIDTH'(sext(MAX_W'(corr_reg), CORR_WIDTH));
  assign pinc_new = base_pinc + (use_corr ? corr_ext : '0);
  assign cfg_word = CFG_W'(pack_cfg(MAX_W'(phase_off), MAX_W'(pinc_new), PINC_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    build     = 1'b0;
    use_corr  = 1'b0;
    consume   = 1'b0;
    case (state)
      ST_INIT: begin
        build     = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: if (cfg_tready) state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      ST_IDLE: if (pending || base_pinc != base_q) begin
        build     = 1'b1;
        use_corr  = 1'b1;
        consume   = 1'b1;
        state_nxt = ST_SEND;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_tready <= 1'b0;
      cfg_tdata   <= '0;
      hold_cnt    <= '0;
      pending     <= 1'b0;
      corr_reg    <= '0;
      base_q      <= '0;
      update_cnt  <= '0;
      drop_cnt    <= '0;
    end else begin
      // tready low only during the INIT cycle, so INIT never captures
      corr_tready <= 1'b1;
      hold_cnt    <= (state == ST_HOLD) ? hold_cnt + HW'(1) : '0;
      if (build) begin
        cfg_tdata <= cfg_word;
        base_q    <= base_pinc;
      end
      // a new capture wins over the consume; the consumed value is the old corr_reg
      if (capture) begin
        corr_reg <= corr_tdata;
        pending  <= 1'b1;
      end else if (consume) begin
        pending  <= 1'b0;
      end
      if (capture && pending && !consume && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (hs && update_cnt != '1)
        update_cnt <= update_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_nco_cfg_ctrl.sv
// Bench for nco_cfg_ctrl: directed vector table, corner sequences and random
// stimulus, all checked against a timestamp-based transaction model.
module tb_nco_cfg_ctrl;
  localparam int PW = 32, CW = 16, HC = 8, NW = 16;

  logic            clk = 1'b0, rst = 1'b1;
  logic [PW-1:0]   base_pinc = '0, phase_off = '0;
  logic [CW-1:0]   corr_tdata = '0;
  logic            corr_tvalid = 1'b0, corr_tready;
  logic [2*PW-1:0] cfg_tdata;
  logic            cfg_tvalid, cfg_tready = 1'b1, busy;
  logic [NW-1:0]   update_cnt, drop_cnt;

  int n_chk = 0, n_fail = 0, cyc_n = 0;

  always #5 clk = ~clk;

  nco_cfg_ctrl #(.PINC_WIDTH(PW), .CORR_WIDTH(CW), .HOLD_CYCLES(HC), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .base_pinc(base_pinc), .phase_off(phase_off),
    .corr_tdata(corr_tdata), .corr_tvalid(corr_tvalid), .corr_tready(corr_tready),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .busy(busy), .update_cnt(update_cnt), .drop_cnt(drop_cnt)
  );

  // Reference model: tracks the current transfer, the latest correction and the
  // earliest edge at which a new config may be built after a handshake.
  logic          m_init, m_valid, m_pend, m_rdy;
  logic [63:0]   m_data;
  logic [CW-1:0] m_corr;
  logic [PW-1:0] m_base;
  logic [NW-1:0] m_upd, m_drop;
  int            m_idle_at, now = 0;

  task automatic model_step();
    bit cap, take;
    int sc;
    if (rst) begin
      m_init = 1; m_valid = 0; m_pend = 0; m_rdy = 0; m_data = '0; m_corr = '0;
      m_base = '0; m_upd = '0; m_drop = '0; m_idle_at = 0;
    end else begin
      cap  = corr_tvalid && m_rdy;
      take = 0;
      if (m_init) begin
        m_data = {phase_off, base_pinc}; m_base = base_pinc; m_valid = 1; m_init = 0;
      end else if (m_valid) begin
        if (cfg_tready) begin
          m_valid = 0; m_idle_at = now + HC + 1;
          if (m_upd != '1) m_upd = m_upd + 1'b1;
        end
      end else if (now >= m_idle_at && (m_pend || base_pinc != m_base)) begin
        sc = int'(signed'(m_corr));
        m_data = {phase_off, base_pinc + sc[PW-1:0]};
        m_base = base_pinc; m_valid = 1; m_pend = 0; take = 1;
      end
      if (cap) begin
        if (m_pend && !take && m_drop != '1) m_drop = m_drop + 1'b1;
        m_corr = corr_tdata; m_pend = 1;
      end
      m_rdy = 1;
    end
    now++;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic tick();
    logic m_busy;
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    m_busy = m_init || m_valid || (now < m_idle_at);
    chk("model", 128'({cfg_tvalid, busy, corr_tready, update_cnt, drop_cnt, cfg_tdata}),
                 128'({m_valid, m_busy, m_rdy, m_upd, m_drop, m_data}));
  endtask

  task automatic wait_valid(input string nm, input int max);
    int k = 0;
    while (cfg_tvalid !== 1'b1 && k < max) begin tick(); k++; end
    chk(nm, 128'(cfg_tvalid), 128'(1));
  endtask

  task automatic wait_idle(input string nm, input int max);
    int k = 0;
    while (busy !== 1'b0 && k < max) begin tick(); k++; end
    chk(nm, 128'(busy), 128'(0));
  endtask

  typedef struct {
    logic rst; int cyc; logic [31:0] base, poff; logic cv; logic [15:0] corr; logic rdy;
    logic ev, eb, etr; logic [63:0] ed; logic [15:0] eu, edr;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int hs_t[$];
    tbl[0]  = '{1, 2, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 1, 0, 64'h0, 0, 0};
    tbl[1]  = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  1, 1, 1, 64'h0000_0000_0100_0000, 0, 0};
    tbl[2]  = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 1, 1, 64'h0000_0000_0100_0000, 1, 0};
    tbl[3]  = '{0, 7, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 1, 1, 64'h0000_0000_0100_0000, 1, 0};
    tbl[4]  = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 0, 1, 64'h0000_0000_0100_0000, 1, 0};
    tbl[5]  = '{0, 1, 32'h0100_0000, 0, 1, 16'h0010, 1,  0, 0, 1, 64'h0000_0000_0100_0000, 1, 0};
    tbl[6]  = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  1, 1, 1, 64'h0000_0000_0100_0010, 1, 0};
    tbl[7]  = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 1, 1, 64'h0000_0000_0100_0010, 2, 0};
    tbl[8]  = '{0, 8, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 0, 1, 64'h0000_0000_0100_0010, 2, 0};
    tbl[9]  = '{0, 1, 32'h0100_0000, 0, 1, 16'hFFFF, 1,  0, 0, 1, 64'h0000_0000_0100_0010, 2, 0};
    tbl[10] = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  1, 1, 1, 64'h0000_0000_00FF_FFFF, 2, 0};
    tbl[11] = '{0, 1, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 1, 1, 64'h0000_0000_00FF_FFFF, 3, 0};
    tbl[12] = '{0, 8, 32'h0100_0000, 0, 0, 16'h0000, 1,  0, 0, 1, 64'h0000_0000_00FF_FFFF, 3, 0};
    // base change and capture on the same IDLE edge: build uses the old correction (-1)
    tbl[13] = '{0, 1, 32'hFFFF_FFF0, 0, 1, 16'h0020, 1,  1, 1, 1, 64'h0000_0000_FFFF_FFEF, 3, 0};
    tbl[14] = '{0, 1, 32'hFFFF_FFF0, 0, 0, 16'h0000, 1,  0, 1, 1, 64'h0000_0000_FFFF_FFEF, 4, 0};
    tbl[15] = '{0, 8, 32'hFFFF_FFF0, 0, 0, 16'h0000, 1,  0, 0, 1, 64'h0000_0000_FFFF_FFEF, 4, 0};
    tbl[16] = '{0, 1, 32'hFFFF_FFF0, 32'h1234_5678, 0, 16'h0000, 1,  1, 1, 1, 64'h1234_5678_0000_0010, 4, 0};
    tbl[17] = '{0, 1, 32'hFFFF_FFF0, 32'h1234_5678, 0, 16'h0000, 1,  0, 1, 1, 64'h1234_5678_0000_0010, 5, 0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; base_pinc = tbl[i].base; phase_off = tbl[i].poff;
      corr_tvalid = tbl[i].cv; corr_tdata = tbl[i].corr; cfg_tready = tbl[i].rdy;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick();
        corr_tvalid = 1'b0;
      end
      chk($sformatf("vec%0d", i),
          128'({cfg_tvalid, busy, corr_tready, cfg_tdata, update_cnt, drop_cnt}),
          128'({tbl[i].ev, tbl[i].eb, tbl[i].etr, tbl[i].ed, tbl[i].eu, tbl[i].edr}));
    end

    // Stalled SEND: data frozen while corrections coalesce, latest one wins
    cfg_tready = 1'b0;
    wait_idle("t4_idle", 20);
    corr_tvalid = 1'b1; corr_tdata = 16'h0001; tick();
    corr_tvalid = 1'b0; tick();
    chk("t4_first", 128'({cfg_tvalid, cfg_tdata}), 128'({1'b1, 64'h1234_5678_FFFF_FFF1}));
    for (int k = 0; k < 10; k++) begin
      corr_tvalid = (k < 3);
      corr_tdata  = 16'(5 + k);
      tick();
      chk("t4_stable", 128'({cfg_tvalid, cfg_tdata}), 128'({1'b1, 64'h1234_5678_FFFF_FFF1}));
    end
    chk("t4_drop", 128'(drop_cnt), 128'(2));
    cfg_tready = 1'b1; tick();
    wait_valid("t4_next_valid", 20);
    chk("t4_pinc", 128'(cfg_tdata), 128'(64'h1234_5678_FFFF_FFF7));

    // Continuous corrections with ready high: handshakes HC+2 cycles apart
    for (int k = 0; k < 45; k++) begin
      corr_tvalid = 1'b1; corr_tdata = 16'($urandom);
      if (cfg_tvalid && cfg_tready) hs_t.push_back(cyc_n);
      tick();
    end
    corr_tvalid = 1'b0;
    chk("t5_hs_count", 128'(hs_t.size() >= 4), 128'(1));
    for (int k = 1; k < hs_t.size(); k++)
      chk("t5_spacing", 128'(hs_t[k] - hs_t[k-1]), 128'(HC + 2));

    // Reset while a transfer is pending
    cfg_tready = 1'b0;
    wait_valid("t6_valid", 30);
    rst = 1'b1; tick();
    chk("t6_rst", 128'({cfg_tvalid, busy, corr_tready, update_cnt, drop_cnt}),
                  128'({1'b0, 1'b1, 1'b0, 16'h0, 16'h0}));
    rst = 1'b0; corr_tvalid = 1'b1; corr_tdata = 16'h0100; tick();
    corr_tvalid = 1'b0;
    chk("t6_init_cfg", 128'({cfg_tvalid, cfg_tdata}), 128'({1'b1, 64'h1234_5678_FFFF_FFF0}));

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      rst         = ($urandom_range(0, 149) == 0);
      corr_tvalid = ($urandom_range(0, 2) == 0);
      corr_tdata  = 16'($urandom);
      cfg_tready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        base_pinc = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : 32'($urandom);
        phase_off = 32'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
